rat_arf_nw: RTL and testbench

Parametrised multi-lane register alias table plus architectural register file for the out-of-order core. It sits between decode/dispatch and the reservation stations/ROB. Each cycle it renames up to `DISPATCH_WIDTH` instructions, with intra-group dependency bypass, and retires up to `COMMIT_WIDTH` ROB entries into architectural state. It replaces the single-lane RAT/ARF when the dispatch and commit paths are widened.

---
 rtl/rv32i_types.sv | 30 +++
 rtl/rat_src_lookup.sv | 57 +++++
 rtl/rat_arf_nw.sv | 133 +++++++++++++
 tb/tb_rat_arf_nw.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the multi-lane RAT/ARF: the table entry layout, lane-array shapes
// and the hardwired zero register. The data and ROB tag widths are fixed here.
package rv32i_types;

  localparam int unsigned RAT_DATA_WIDTH     = 32;
  localparam int unsigned RAT_ROB_IDX_WIDTH  = 5;
  localparam int unsigned RAT_REG_ADDR_WIDTH = 5;
  localparam int unsigned RAT_DISP_LANES     = 2;
  localparam int unsigned RAT_COMMIT_LANES   = 2;

  localparam logic [4:0] ARCH_REG_ZERO = 5'd0;

  typedef logic [RAT_REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [RAT_DATA_WIDTH-1:0]     reg_data_t;
  typedef logic [RAT_ROB_IDX_WIDTH-1:0]  rob_idx_t;

  typedef struct packed {
    reg_data_t data;
    logic      ready;
    rob_idx_t  rob_idx;
  } rat_arf_entry_t;

  // Lane-array shapes for the default lane counts.
  typedef logic [RAT_DISP_LANES-1:0][RAT_REG_ADDR_WIDTH-1:0]   disp_addr_arr_t;
  typedef logic [RAT_DISP_LANES-1:0][RAT_ROB_IDX_WIDTH-1:0]    disp_rob_arr_t;
  typedef logic [RAT_COMMIT_LANES-1:0][RAT_REG_ADDR_WIDTH-1:0] commit_addr_arr_t;
  typedef logic [RAT_COMMIT_LANES-1:0][RAT_ROB_IDX_WIDTH-1:0]  commit_rob_arr_t;
  typedef logic [RAT_COMMIT_LANES-1:0][RAT_DATA_WIDTH-1:0]     commit_data_arr_t;

endpackage

// File: rtl/rat_src_lookup.sv
// Single source-operand lookup: table read, bypass from older lanes of the same
// dispatch group, and (with RAT_COMMIT_BYPASS_EN) forwarding of a same-cycle commit.
module rat_src_lookup
  import rv32i_types::*;
#(
  parameter int unsigned LANE           = 0,
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned COMMIT_WIDTH   = 2
) (
  input  logic [4:0]                                       src_addr_i,
  input  rat_arf_entry_t                                   entry_i,
  input  logic [DISPATCH_WIDTH-1:0]                        disp_valid_i,
  input  logic [DISPATCH_WIDTH-1:0][4:0]                   disp_rd_addr_i,
  input  logic [DISPATCH_WIDTH-1:0][RAT_ROB_IDX_WIDTH-1:0] disp_rob_idx_i,
`ifdef RAT_COMMIT_BYPASS_EN
  input  logic [COMMIT_WIDTH-1:0]                          commit_valid_i,
  input  logic [COMMIT_WIDTH-1:0][4:0]                     commit_rd_addr_i,
  input  logic [COMMIT_WIDTH-1:0][RAT_ROB_IDX_WIDTH-1:0]   commit_rob_idx_i,
  input  logic [COMMIT_WIDTH-1:0][RAT_DATA_WIDTH-1:0]      commit_data_i,
`endif
  output logic                                             rdy_o,
  output logic [RAT_ROB_IDX_WIDTH-1:0]                     rob_idx_o,
  output logic [RAT_DATA_WIDTH-1:0]                        data_o
);

  // Later assignments override earlier ones: commit bypass, then older-lane bypass, then x0.
  always_comb begin
    rdy_o     = entry_i.ready;
    rob_idx_o = entry_i.rob_idx;
    data_o    = entry_i.data;
`ifdef RAT_COMMIT_BYPASS_EN
    if (!entry_i.ready) begin
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
        if (commit_valid_i[k] && commit_rd_addr_i[k] == src_addr_i &&
            commit_rd_addr_i[k] != ARCH_REG_ZERO && commit_rob_idx_i[k] == entry_i.rob_idx) begin
          rdy_o  = 1'b1;
          data_o = commit_data_i[k];
        end
      end
    end
`endif
    // Only lanes older than this one may supply a producer; the youngest of them wins.
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      if (i < LANE && disp_valid_i[i] && disp_rd_addr_i[i] == src_addr_i &&
          disp_rd_addr_i[i] != ARCH_REG_ZERO) begin
        rdy_o     = 1'b0;
        rob_idx_o = disp_rob_idx_i[i];
      end
    end
    if (src_addr_i == ARCH_REG_ZERO) begin
      rdy_o     = 1'b1;
      rob_idx_o = '0;
      data_o    = '0;
    end
  end

endmodule

// File: rtl/rat_arf_nw.sv
// Multi-lane register alias table plus architectural register file. Renames up to
// DISPATCH_WIDTH instructions per cycle and retires up to COMMIT_WIDTH results.
// Optional feature macro: RAT_COMMIT_BYPASS_EN forwards same-cycle commits to lookups.
module rat_arf_nw
  import rv32i_types::*;
#(
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned COMMIT_WIDTH   = 2,
  // Entry widths follow the shared entry struct.
  localparam int unsigned DATA_WIDTH    = RAT_DATA_WIDTH,
  localparam int unsigned ROB_IDX_WIDTH = RAT_ROB_IDX_WIDTH,
  localparam int unsigned CntW          = $clog2(NUM_REGS) + 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     flush,
  input  logic [DISPATCH_WIDTH-1:0]                disp_valid,
  input  logic [DISPATCH_WIDTH-1:0][4:0]           disp_rd_addr,
  input  logic [DISPATCH_WIDTH-1:0][4:0]           disp_rs1_addr,
  input  logic [DISPATCH_WIDTH-1:0][4:0]           disp_rs2_addr,
  input  logic [DISPATCH_WIDTH-1:0][ROB_IDX_WIDTH-1:0] disp_rob_idx,
  output logic [DISPATCH_WIDTH-1:0]                rs1_rdy,
  output logic [DISPATCH_WIDTH-1:0]                rs2_rdy,
  output logic [DISPATCH_WIDTH-1:0][ROB_IDX_WIDTH-1:0] rs1_rob_idx,
  output logic [DISPATCH_WIDTH-1:0][ROB_IDX_WIDTH-1:0] rs2_rob_idx,
  output logic [DISPATCH_WIDTH-1:0][DATA_WIDTH-1:0]    rs1_data,
  output logic [DISPATCH_WIDTH-1:0][DATA_WIDTH-1:0]    rs2_data,
  input  logic [COMMIT_WIDTH-1:0]                  commit_valid,
  input  logic [COMMIT_WIDTH-1:0][4:0]             commit_rd_addr,
  input  logic [COMMIT_WIDTH-1:0][ROB_IDX_WIDTH-1:0]   commit_rob_idx,
  input  logic [COMMIT_WIDTH-1:0][DATA_WIDTH-1:0]      commit_data,
  output logic [CntW-1:0]                          pending_count
);

  rat_arf_entry_t table_q [NUM_REGS];
  rat_arf_entry_t table_d [NUM_REGS];
  logic [CntW-1:0] pending_count_q, pending_count_d;

  assign pending_count = pending_count_q;

  // Next-state table: commits first, then flush or dispatch overrides ready/rob_idx.
  always_comb begin
    table_d = table_q;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      if (commit_valid[k] && commit_rd_addr[k] != ARCH_REG_ZERO) begin
        table_d[commit_rd_addr[k]].data = commit_data[k];
        // A stale tag leaves ready at its pre-edge value, so the youngest lane decides.
        table_d[commit_rd_addr[k]].ready =
            (table_q[commit_rd_addr[k]].rob_idx == commit_rob_idx[k]) ? 1'b1 :
            table_q[commit_rd_addr[k]].ready;
      end
    end
    if (flush) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        table_d[r].ready = 1'b1;
      end
    end else begin
      for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
        if (disp_valid[i] && disp_rd_addr[i] != ARCH_REG_ZERO) begin
          table_d[disp_rd_addr[i]].ready   = 1'b0;
          table_d[disp_rd_addr[i]].rob_idx = disp_rob_idx[i];
        end
      end
    end
  end

  // Count of in-flight destinations in the next-state table, x0 excluded.
  always_comb begin
    pending_count_d = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      pending_count_d = pending_count_d + {{(CntW-1){1'b0}}, ~table_d[r].ready};
    end
  end

  // Table and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        table_q[r] <= '{data: '0, ready: 1'b1, rob_idx: '0};
      end
      pending_count_q <= '0;
    end else begin
      table_q         <= table_d;
      pending_count_q <= pending_count_d;
    end
  end

  for (genvar j = 0; j < DISPATCH_WIDTH; j++) begin : g_lane
    rat_src_lookup #(
      .LANE          (j),
      .DISPATCH_WIDTH(DISPATCH_WIDTH),
      .COMMIT_WIDTH  (COMMIT_WIDTH)
    ) u_rs1 (
      .src_addr_i      (disp_rs1_addr[j]),
      .entry_i         (table_q[disp_rs1_addr[j]]),
      .disp_valid_i    (disp_valid),
      .disp_rd_addr_i  (disp_rd_addr),
      .disp_rob_idx_i  (disp_rob_idx),
`ifdef RAT_COMMIT_BYPASS_EN
      .commit_valid_i  (commit_valid),
      .commit_rd_addr_i(commit_rd_addr),
      .commit_rob_idx_i(commit_rob_idx),
      .commit_data_i   (commit_data),
`endif
      .rdy_o           (rs1_rdy[j]),
      .rob_idx_o       (rs1_rob_idx[j]),
      .data_o          (rs1_data[j])
    );

    rat_src_lookup #(
      .LANE          (j),
      .DISPATCH_WIDTH(DISPATCH_WIDTH),
      .COMMIT_WIDTH  (COMMIT_WIDTH)
    ) u_rs2 (
      .src_addr_i      (disp_rs2_addr[j]),
      .entry_i         (table_q[disp_rs2_addr[j]]),
      .disp_valid_i    (disp_valid),
      .disp_rd_addr_i  (disp_rd_addr),
      .disp_rob_idx_i  (disp_rob_idx),
`ifdef RAT_COMMIT_BYPASS_EN
      .commit_valid_i  (commit_valid),
      .commit_rd_addr_i(commit_rd_addr),
      .commit_rob_idx_i(commit_rob_idx),
      .commit_data_i   (commit_data),
`endif
      .rdy_o           (rs2_rdy[j]),
      .rob_idx_o       (rs2_rob_idx[j]),
      .data_o          (rs2_data[j])
    );
  end

endmodule

// File: tb/tb_rat_arf_nw.sv
// Scoreboard bench for rat_arf_nw: a behavioural register-table model predicts each
// cycle's lookups and pending count; a negedge monitor pops and compares.
module tb_rat_arf_nw;

  localparam int DW = 2;
  localparam int CW = 2;

  logic clk, rst, flush;
  logic [DW-1:0]        disp_valid;
  logic [DW-1:0][4:0]   disp_rd_addr, disp_rs1_addr, disp_rs2_addr, disp_rob_idx;
  logic [DW-1:0]        rs1_rdy, rs2_rdy;
  logic [DW-1:0][4:0]   rs1_rob_idx, rs2_rob_idx;
  logic [DW-1:0][31:0]  rs1_data, rs2_data;
  logic [CW-1:0]        commit_valid;
  logic [CW-1:0][4:0]   commit_rd_addr, commit_rob_idx;
  logic [CW-1:0][31:0]  commit_data;
  logic [5:0]           pending_count;

  int checks = 0;
  int failures = 0;

  rat_arf_nw dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_rd_addr  (disp_rd_addr),
    .disp_rs1_addr (disp_rs1_addr),
    .disp_rs2_addr (disp_rs2_addr),
    .disp_rob_idx  (disp_rob_idx),
    .rs1_rdy       (rs1_rdy),
    .rs2_rdy       (rs2_rdy),
    .rs1_rob_idx   (rs1_rob_idx),
    .rs2_rob_idx   (rs2_rob_idx),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .commit_valid  (commit_valid),
    .commit_rd_addr(commit_rd_addr),
    .commit_rob_idx(commit_rob_idx),
    .commit_data   (commit_data),
    .pending_count (pending_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference architectural state.
  bit [31:0] m_data [32];
  bit        m_rdy  [32];
  bit [4:0]  m_tag  [32];

  typedef struct {
    bit [DW-1:0][1:0]       rdy;
    bit [DW-1:0][1:0][4:0]  rob;
    bit [DW-1:0][1:0][31:0] data;
    bit [5:0]               cnt;
  } exp_t;

  exp_t exp_q [$];

  task automatic check(input string name, input int lane, input logic [31:0] act,
                       input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h", name, lane, act, expv);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    int cnt;
    for (int j = 0; j < DW; j++) begin
      for (int s = 0; s < 2; s++) begin
        bit [4:0] src;
        bit r;
        bit [4:0] rob;
        bit [31:0] d;
        src = (s == 0) ? disp_rs1_addr[j] : disp_rs2_addr[j];
        r = 1'b1; rob = '0; d = '0;
        if (src != 0) begin
          r = m_rdy[src]; rob = m_tag[src]; d = m_data[src];
`ifdef RAT_COMMIT_BYPASS_EN
          if (!m_rdy[src]) begin
            for (int k = CW - 1; k >= 0; k--) begin
              if (commit_valid[k] && commit_rd_addr[k] == src && commit_rob_idx[k] == m_tag[src]) begin
                r = 1'b1; d = commit_data[k];
                break;
              end
            end
          end
`endif
          for (int i = j - 1; i >= 0; i--) begin
            if (disp_valid[i] && disp_rd_addr[i] == src) begin
              r = 1'b0; rob = disp_rob_idx[i];
              break;
            end
          end
        end
        e.rdy[j][s] = r; e.rob[j][s] = rob; e.data[j][s] = d;
      end
    end
    cnt = 0;
    for (int r = 1; r < 32; r++) if (!m_rdy[r]) cnt++;
    e.cnt = 6'(cnt);
    return e;
  endfunction

  task automatic model_update();
    bit [4:0] old_tag [32];
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_data[r] = '0; m_rdy[r] = 1'b1; m_tag[r] = '0;
      end
      return;
    end
    old_tag = m_tag;
    for (int k = 0; k < CW; k++) begin
      bit youngest = 1'b1;
      for (int k2 = k + 1; k2 < CW; k2++)
        if (commit_valid[k2] && commit_rd_addr[k2] == commit_rd_addr[k]) youngest = 1'b0;
      if (commit_valid[k] && commit_rd_addr[k] != 0 && youngest) begin
        m_data[commit_rd_addr[k]] = commit_data[k];
        if (old_tag[commit_rd_addr[k]] == commit_rob_idx[k]) m_rdy[commit_rd_addr[k]] = 1'b1;
      end
    end
    if (flush) begin
      for (int r = 0; r < 32; r++) m_rdy[r] = 1'b1;
    end else begin
      for (int i = 0; i < DW; i++) begin
        bit youngest = 1'b1;
        for (int i2 = i + 1; i2 < DW; i2++)
          if (disp_valid[i2] && disp_rd_addr[i2] == disp_rd_addr[i]) youngest = 1'b0;
        if (disp_valid[i] && disp_rd_addr[i] != 0 && youngest) begin
          m_rdy[disp_rd_addr[i]] = 1'b0;
          m_tag[disp_rd_addr[i]] = disp_rob_idx[i];
        end
      end
    end
  endtask

  // Monitor: compare whatever the driver predicted for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int j = 0; j < DW; j++) begin
        check("sb_rs1_rdy", j, 32'(rs1_rdy[j]), 32'(e.rdy[j][0]));
        check("sb_rs2_rdy", j, 32'(rs2_rdy[j]), 32'(e.rdy[j][1]));
        if (e.rdy[j][0]) check("sb_rs1_data", j, rs1_data[j], e.data[j][0]);
        else             check("sb_rs1_rob", j, 32'(rs1_rob_idx[j]), 32'(e.rob[j][0]));
        if (e.rdy[j][1]) check("sb_rs2_data", j, rs2_data[j], e.data[j][1]);
        else             check("sb_rs2_rob", j, 32'(rs2_rob_idx[j]), 32'(e.rob[j][1]));
      end
      check("sb_pending_count", 0, 32'(pending_count), 32'(e.cnt));
    end
  end

  task automatic clear_inputs();
    flush = 1'b0;
    disp_valid = '0; disp_rd_addr = '0; disp_rs1_addr = '0; disp_rs2_addr = '0;
    disp_rob_idx = '0;
    commit_valid = '0; commit_rd_addr = '0; commit_rob_idx = '0; commit_data = '0;
  endtask

  // Predict this cycle, then apply the edge to the model.
  task automatic step();
    if (!rst) exp_q.push_back(predict());
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_inputs();
    int n;
    clear_inputs();
    n = $urandom_range(0, 2);
    disp_valid = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
    for (int i = 0; i < DW; i++) begin
      disp_rd_addr[i]  = 5'($urandom_range(0, 7));
      disp_rs1_addr[i] = 5'($urandom_range(0, 7));
      disp_rs2_addr[i] = 5'($urandom_range(0, 7));
      disp_rob_idx[i]  = 5'($urandom);
    end
    n = $urandom_range(0, 2);
    commit_valid = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
    for (int k = 0; k < CW; k++) begin
      commit_rd_addr[k] = 5'($urandom_range(0, 7));
      commit_rob_idx[k] = ($urandom_range(0, 1) == 1) ? m_tag[commit_rd_addr[k]] : 5'($urandom);
      commit_data[k]    = $urandom;
    end
    flush = ($urandom_range(0, 15) == 0);
    rst   = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog lane0: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    model_update();
    #1;
    step();
    rst = 1'b0;

    // Reset state.
    clear_inputs();
    disp_rs1_addr[0] = 5'd5;
    #1;
    check("reset_rdy", 0, 32'(rs1_rdy[0]), 32'd1);
    check("reset_data", 0, rs1_data[0], 32'd0);
    check("reset_count", 0, 32'(pending_count), 32'd0);
    step();

    // Rename then commit.
    clear_inputs();
    disp_valid = 2'b01; disp_rd_addr[0] = 5'd3; disp_rob_idx[0] = 5'd7;
    step();
    clear_inputs();
    disp_rs1_addr[0] = 5'd3;
    commit_valid = 2'b01; commit_rd_addr[0] = 5'd3; commit_rob_idx[0] = 5'd7;
    commit_data[0] = 32'hAB;
    #1;
`ifdef RAT_COMMIT_BYPASS_EN
    check("rename_bypass_rdy", 0, 32'(rs1_rdy[0]), 32'd1);
    check("rename_bypass_data", 0, rs1_data[0], 32'hAB);
`else
    check("rename_rdy", 0, 32'(rs1_rdy[0]), 32'd0);
    check("rename_rob", 0, 32'(rs1_rob_idx[0]), 32'd7);
`endif
    step();
    clear_inputs();
    disp_rs1_addr[0] = 5'd3;
    #1;
    check("commit_rdy", 0, 32'(rs1_rdy[0]), 32'd1);
    check("commit_data", 0, rs1_data[0], 32'hAB);
    step();

    // Intra-group bypass.
    clear_inputs();
    disp_valid = 2'b11; disp_rd_addr[0] = 5'd4; disp_rob_idx[0] = 5'd2;
    disp_rs2_addr[1] = 5'd4;
    #1;
    check("group_rs2_rdy", 1, 32'(rs2_rdy[1]), 32'd0);
    check("group_rs2_rob", 1, 32'(rs2_rob_idx[1]), 32'd2);
    step();
    clear_inputs();
    disp_valid = 2'b11;
    disp_rd_addr[0] = 5'd6; disp_rob_idx[0] = 5'd8;
    disp_rd_addr[1] = 5'd6; disp_rob_idx[1] = 5'd9;
    step();
    clear_inputs();
    disp_rs1_addr[0] = 5'd6;
    #1;
    check("same_rd_rob", 0, 32'(rs1_rob_idx[0]), 32'd9);
    step();

    // Stale commit and x0 commit.
    clear_inputs();
    disp_valid = 2'b01; disp_rd_addr[0] = 5'd3; disp_rob_idx[0] = 5'd9;
    step();
    clear_inputs();
    commit_valid = 2'b01; commit_rd_addr[0] = 5'd3; commit_rob_idx[0] = 5'd7;
    commit_data[0] = 32'h11;
    step();
    clear_inputs();
    disp_rs1_addr[0] = 5'd3;
    commit_valid = 2'b01; commit_rd_addr[0] = 5'd0; commit_data[0] = 32'h55;
    #1;
    check("stale_rdy", 0, 32'(rs1_rdy[0]), 32'd0);
    check("stale_rob", 0, 32'(rs1_rob_idx[0]), 32'd9);
    step();
    clear_inputs();
    #1;
    check("x0_rdy", 0, 32'(rs1_rdy[0]), 32'd1);
    check("x0_data", 0, rs1_data[0], 32'd0);
    check("three_pending", 0, 32'(pending_count), 32'd3);
    step();

    // Flush with dispatch and commit in the same cycle.
    clear_inputs();
    flush = 1'b1;
    disp_valid = 2'b01; disp_rd_addr[0] = 5'd8; disp_rob_idx[0] = 5'd20;
    commit_valid = 2'b01; commit_rd_addr[0] = 5'd2; commit_rob_idx[0] = 5'd0;
    commit_data[0] = 32'h33;
    step();
    clear_inputs();
    disp_rs1_addr[0] = 5'd3; disp_rs2_addr[0] = 5'd2; disp_rs1_addr[1] = 5'd8;
    #1;
    check("flush_count", 0, 32'(pending_count), 32'd0);
    check("flush_rs1_rdy", 0, 32'(rs1_rdy[0]), 32'd1);
    check("flush_stale_data", 0, rs1_data[0], 32'h11);
    check("flush_commit_data", 0, rs2_data[0], 32'h33);
    check("flush_rd8_rdy", 1, 32'(rs1_rdy[1]), 32'd1);
    step();

    // Commit bypass.
    clear_inputs();
    disp_valid = 2'b01; disp_rd_addr[0] = 5'd5; disp_rob_idx[0] = 5'd4;
    step();
    clear_inputs();
    disp_rs1_addr[0] = 5'd5;
    commit_valid = 2'b01; commit_rd_addr[0] = 5'd5; commit_rob_idx[0] = 5'd4;
    commit_data[0] = 32'h99;
    #1;
`ifdef RAT_COMMIT_BYPASS_EN
    check("cbyp_rdy", 0, 32'(rs1_rdy[0]), 32'd1);
    check("cbyp_data", 0, rs1_data[0], 32'h99);
`else
    check("cbyp_rdy", 0, 32'(rs1_rdy[0]), 32'd0);
    check("cbyp_rob", 0, 32'(rs1_rob_idx[0]), 32'd4);
`endif
    step();
    clear_inputs();
    disp_rs1_addr[0] = 5'd5;
    #1;
    check("cbyp_next_rdy", 0, 32'(rs1_rdy[0]), 32'd1);
    check("cbyp_next_data", 0, rs1_data[0], 32'h99);
    step();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      step();
    end
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    #1;
    check("queue_drain", 0, 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
